// File: rtl/mips_data_mem_ctrl.sv
// mips_data_mem_ctrl
// Load/store access controller between the MIPS32 memory stage and a
// word-addressed data memory port. It takes one byte/halfword/word request
// at a time and turns it into a single word access. Stores use big-endian
// byte-lane enables and replicated write data. Loads wait for DataMem_Ready
// and return the aligned result, sign- or zero-extended.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   req_*               request (valid/we/size/signed/addr/wdata), taken in IDLE
//   busy                high while an access is in flight
//   done                one-cycle completion pulse
//   rdata               load result (valid with done)
//   addr_err, bus_err   error qualifiers (only with done)
//   DataMem_*           word-addressed memory port
//   dbg_state           current FSM state, for observation only
//
// Handshake: a request is taken on any rising edge where req_valid=1 and the
// controller is IDLE. busy=0 (which includes the done cycle) means the
// controller is ready. A load drives DataMem_Read for exactly one cycle. The
// memory then answers with a single-cycle DataMem_Ready pulse and the
// matching DataMem_In. Ready is only honoured in WAIT. Stores are
// fire-and-forget and never wait for DataMem_Ready.
module mips_data_mem_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        bus_err,
  output logic        DataMem_Read,
  output logic [3:0]  DataMem_Write,
  output logic [29:0] DataMem_Address,
  output logic [31:0] DataMem_Out,
  input  logic [31:0] DataMem_In,
  input  logic        DataMem_Ready,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  // Counter value in the last allowed WAIT cycle.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        done_q, done_d;
  logic        addr_err_q, addr_err_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rd_q, rd_d;
  logic [3:0]  wr_q, wr_d;
  logic [29:0] maddr_q, maddr_d;
  logic [31:0] mout_q, mout_d;

  logic [3:0]  st_en;
  logic [31:0] st_data;
  logic        misaligned;

  // Pick the addressed byte or halfword out of the big-endian word, then
  // extend it.
  function automatic logic [31:0] fmt_load(input logic [31:0] w,
                                           input logic [1:0]  sz,
                                           input logic [1:0]  k,
                                           input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (k)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = k[1] ? w[15:0] : w[31:16];
    case (sz)
      2'b00:   r = sgn ? {{24{b[7]}}, b} : {24'b0, b};
      2'b01:   r = sgn ? {{16{h[15]}}, h} : {16'b0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Lane enables and replicated data for a store issued from the live
  // request inputs. These are only used on the accepting edge.
  always_comb begin
    st_en      = 4'b1111;
    st_data    = req_wdata;
    misaligned = 1'b0;
    case (req_size)
      2'b00: begin
        st_en   = 4'b1000 >> req_addr[1:0];
        st_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_en      = req_addr[1] ? 4'b0011 : 4'b1100;
        st_data    = {2{req_wdata[15:0]}};
        misaligned = req_addr[0];
      end
      2'b10: misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    off_d      = off_q;
    size_d     = size_q;
    signed_d   = signed_q;
    maddr_d    = maddr_q;
    done_d     = 1'b0;
    addr_err_d = 1'b0;
    bus_err_d  = 1'b0;
    rdata_d    = 32'h0;
    rd_d       = 1'b0;
    wr_d       = 4'b0000;
    mout_d     = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          off_d    = req_addr[1:0];
          size_d   = req_size;
          signed_d = req_signed;
          if (misaligned) begin
            // Rejected without touching memory. The address port keeps
            // its old value.
            done_d     = 1'b1;
            addr_err_d = 1'b1;
          end else begin
            maddr_d = req_addr[31:2];
            if (req_we) begin
              state_d = S_WRITE;
              wr_d    = st_en;
              mout_d  = st_data;
            end else begin
              state_d = S_READ;
              rd_d    = 1'b1;
            end
          end
        end
      end
      S_READ: begin
        state_d = S_WAIT;
        cnt_d   = 8'd0;
      end
      S_WAIT: begin
        // Ready wins even in the last allowed cycle.
        if (DataMem_Ready) begin
          rdata_d = fmt_load(DataMem_In, size_q, off_q, signed_q);
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == TO_LAST) begin
          done_d    = 1'b1;
          bus_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WRITE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      off_q      <= 2'd0;
      size_q     <= 2'd0;
      signed_q   <= 1'b0;
      done_q     <= 1'b0;
      addr_err_q <= 1'b0;
      bus_err_q  <= 1'b0;
      rdata_q    <= 32'h0;
      rd_q       <= 1'b0;
      wr_q       <= 4'b0000;
      maddr_q    <= 30'h0;
      mout_q     <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      off_q      <= off_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      done_q     <= done_d;
      addr_err_q <= addr_err_d;
      bus_err_q  <= bus_err_d;
      rdata_q    <= rdata_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      maddr_q    <= maddr_d;
      mout_q     <= mout_d;
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign done            = done_q;
  assign rdata           = rdata_q;
  assign addr_err        = addr_err_q;
  assign bus_err         = bus_err_q;
  assign DataMem_Read    = rd_q;
  assign DataMem_Write   = wr_q;
  assign DataMem_Address = maddr_q;
  assign DataMem_Out     = mout_q;
  assign dbg_state       = state_q;

endmodule
